brq_dmem_responder: RTL and testbench

- Memory-side responder for the core's data-memory interface. It sits opposite the core's load/store stage and drives Data_mem_dataOut back into the pipeline.
- Holds a byte-addressed, word-organised RAM with byte-lane writes, load alignment and sign/zero extension, misalignment and protocol checks, and a zero-initialisation sweep after reset.

---
 rtl/brq_dmem_pkg.sv | 31 +++
 rtl/brq_dmem_lane_align.sv | 73 +++++++
 rtl/brq_dmem_responder.sv | 165 ++++++++++++++++
 tb/tb_brq_dmem_responder.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brq_dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : brq_dmem_pkg
// Description : Shared types and constants for the brq data-memory responder:
//               access-size codes (func3 encoding), responder FSM states and
//               lane geometry of the word-organised RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package brq_dmem_pkg;

    // Access size in func3 encoding; 011, 110 and 111 are reserved.
    typedef enum logic [2:0] {
        LS_B  = 3'b000,
        LS_H  = 3'b001,
        LS_W  = 3'b010,
        LS_BU = 3'b100,
        LS_HU = 3'b101
    } ldst_size_e;

    // Responder FSM: zeroing sweep, then serving requests.
    typedef enum logic [0:0] {
        DMEM_INIT = 1'b0,
        DMEM_IDLE = 1'b1
    } dmem_state_e;

    localparam int c_num_lanes = 4;
    localparam int c_byte_w    = 8;
    localparam int c_word_w    = c_num_lanes * c_byte_w;

endpackage
`default_nettype wire

// File: rtl/brq_dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : brq_dmem_lane_align
// Description : Combinational lane steering for the data-memory responder.
//               Builds the byte strobe and replicated store data, flags
//               misaligned or reserved-size accesses, and extracts/extends the
//               addressed lane of a RAM word for loads.
// Revision    : 1.0 - initial release
// ============================================================================
module brq_dmem_lane_align
    import brq_dmem_pkg::*;
(
    input  logic [2:0]               i_size,
    input  logic [1:0]               i_offset,
    input  logic [c_word_w-1:0]      i_store_data,
    input  logic [c_word_w-1:0]      i_load_word,
    output logic [c_num_lanes-1:0]   o_store_strb,
    output logic [c_word_w-1:0]      o_store_data,
    output logic                     o_misaligned,
    output logic [c_word_w-1:0]      o_load_data
);

    logic [c_word_w-1:0] w_shifted;

    // Decode size/offset into strobe, replicated data, misalign flag and load value.
    always_comb begin
        o_store_strb = '0;
        o_store_data = '0;
        o_misaligned = 1'b0;
        o_load_data  = '0;
        w_shifted    = i_load_word >> {i_offset, 3'b000};
        case (i_size)
            LS_B: begin
                o_store_strb = 4'b0001 << i_offset;
                o_store_data = {4{i_store_data[7:0]}};
                o_load_data  = {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            LS_BU: begin
                o_store_strb = 4'b0001 << i_offset;
                o_store_data = {4{i_store_data[7:0]}};
                o_load_data  = {24'h0, w_shifted[7:0]};
            end
            LS_H: begin
                o_misaligned = i_offset[0];
                o_store_strb = 4'b0011 << i_offset;
                o_store_data = {2{i_store_data[15:0]}};
                o_load_data  = {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            LS_HU: begin
                o_misaligned = i_offset[0];
                o_store_strb = 4'b0011 << i_offset;
                o_store_data = {2{i_store_data[15:0]}};
                o_load_data  = {16'h0, w_shifted[15:0]};
            end
            LS_W: begin
                o_misaligned = |i_offset;
                o_store_strb = 4'b1111;
                o_store_data = i_store_data;
                o_load_data  = i_load_word;
            end
            default: begin
                // Reserved size codes are rejected like a misaligned access.
                o_misaligned = 1'b1;
            end
        endcase
        // A rejected access must never touch memory.
        if (o_misaligned) begin
            o_store_strb = '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/brq_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : brq_dmem_responder
// Description : Memory-side responder for the core data-memory interface.
//               Word-organised RAM with byte-lane stores, 1-cycle registered
//               aligned loads with sign/zero extension, misalignment and
//               protocol error pulses, sticky error flag, and an optional
//               zeroing sweep after reset (INIT_CLEAR).
//               Optional build macro BRQ_DMEM_PERF_CNT_EN adds load/store
//               performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module brq_dmem_responder
    import brq_dmem_pkg::*;
#(
    parameter int DataWidth  = 32,
    parameter int AddrWidth  = 15,
    parameter int INIT_CLEAR = 1
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst,
    input  logic [AddrWidth-1:0] Data_mem_address,
    input  logic [DataWidth-1:0] Data_mem_dataIn,
    input  logic                 Data_mem_read_en,
    input  logic                 Data_mem_write_en,
    input  logic [2:0]           ldst_byte_en,
    output logic [DataWidth-1:0] Data_mem_dataOut,
    output logic                 dmem_ready,
    output logic                 dmem_misalign_err,
    output logic                 dmem_proto_err,
    output logic                 dmem_err_sticky
`ifdef BRQ_DMEM_PERF_CNT_EN
    ,
    output logic [31:0]          dmem_load_cnt,
    output logic [31:0]          dmem_store_cnt
`endif
);

    localparam int c_idx_w = AddrWidth - 2;
    localparam int c_depth = 1 << c_idx_w;

    dmem_state_e                r_state;
    dmem_state_e                w_state_nxt;
    logic [c_idx_w-1:0]         r_init_idx;
    logic [c_idx_w-1:0]         w_init_idx_nxt;
    logic [DataWidth-1:0]       r_mem [c_depth];

    logic [c_idx_w-1:0]         w_word_idx;
    logic [1:0]                 w_offset;
    logic [DataWidth-1:0]       w_rd_word;
    logic [c_num_lanes-1:0]     w_strb;
    logic [DataWidth-1:0]       w_wdata;
    logic [DataWidth-1:0]       w_load_data;
    logic                       w_misaligned;
    logic                       w_ready;
    logic                       w_req;
    logic                       w_store;
    logic                       w_load_any;
    logic                       w_load_ok;
    logic                       w_mis_pulse;
    logic                       w_proto_pulse;

    assign w_word_idx    = Data_mem_address[AddrWidth-1:2];
    assign w_offset      = Data_mem_address[1:0];
    assign w_rd_word     = r_mem[w_word_idx];

    assign w_ready       = (r_state == DMEM_IDLE);
    assign w_req         = w_ready & (Data_mem_read_en | Data_mem_write_en);
    assign w_mis_pulse   = w_req & w_misaligned;
    assign w_proto_pulse = w_ready & Data_mem_read_en & Data_mem_write_en;
    // Write takes priority when both enables are high.
    assign w_store       = w_ready & Data_mem_write_en & ~w_misaligned;
    assign w_load_any    = w_ready & Data_mem_read_en & ~Data_mem_write_en;
    assign w_load_ok     = w_load_any & ~w_misaligned;

    assign dmem_ready    = w_ready;

    brq_dmem_lane_align u_lane_align (
        .i_size       (ldst_byte_en),
        .i_offset     (w_offset),
        .i_store_data (Data_mem_dataIn),
        .i_load_word  (w_rd_word),
        .o_store_strb (w_strb),
        .o_store_data (w_wdata),
        .o_misaligned (w_misaligned),
        .o_load_data  (w_load_data)
    );

    // FSM state and sweep index register; reset restarts the sweep from word 0.
    always_ff @(posedge brq_clk or negedge brq_rst) begin
        if (!brq_rst) begin
            r_state    <= (INIT_CLEAR != 0) ? DMEM_INIT : DMEM_IDLE;
            r_init_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_idx <= w_init_idx_nxt;
        end
    end

    // Next-state logic: sweep one word per cycle, leave INIT after the last word.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_idx_nxt = r_init_idx;
        case (r_state)
            DMEM_INIT: begin
                w_init_idx_nxt = r_init_idx + 1'b1;
                if (&r_init_idx) begin
                    w_state_nxt = DMEM_IDLE;
                end
            end
            default: begin
                w_state_nxt = DMEM_IDLE;
            end
        endcase
    end

    // RAM write port: zeroing sweep during INIT, byte-lane stores in IDLE.
    always_ff @(posedge brq_clk) begin
        if (r_state == DMEM_INIT) begin
            r_mem[r_init_idx] <= '0;
        end else if (w_store) begin
            for (int l = 0; l < c_num_lanes; l++) begin
                if (w_strb[l]) begin
                    r_mem[w_word_idx][l*c_byte_w +: c_byte_w] <= w_wdata[l*c_byte_w +: c_byte_w];
                end
            end
        end
    end

    // Registered load result and error flags.
    always_ff @(posedge brq_clk or negedge brq_rst) begin
        if (!brq_rst) begin
            Data_mem_dataOut  <= '0;
            dmem_misalign_err <= 1'b0;
            dmem_proto_err    <= 1'b0;
            dmem_err_sticky   <= 1'b0;
        end else begin
            if (w_load_any) begin
                Data_mem_dataOut <= w_misaligned ? '0 : w_load_data;
            end
            dmem_misalign_err <= w_mis_pulse;
            dmem_proto_err    <= w_proto_pulse;
            dmem_err_sticky   <= dmem_err_sticky | w_mis_pulse | w_proto_pulse;
        end
    end

`ifdef BRQ_DMEM_PERF_CNT_EN
    // Accepted aligned load/store counters, free-running with wrap.
    always_ff @(posedge brq_clk or negedge brq_rst) begin
        if (!brq_rst) begin
            dmem_load_cnt  <= '0;
            dmem_store_cnt <= '0;
        end else begin
            if (w_load_ok) begin
                dmem_load_cnt <= dmem_load_cnt + 32'd1;
            end
            if (w_store) begin
                dmem_store_cnt <= dmem_store_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_brq_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_brq_dmem_responder
// Description : Scoreboard testbench for brq_dmem_responder (AddrWidth=6,
//               16 words). A byte-array reference model predicts each cycle's
//               response; a monitor compares on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_brq_dmem_responder;

    localparam int c_aw = 6;

    logic        clk;
    logic        rst_n;
    logic [5:0]  addr;
    logic [31:0] din;
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  sz;
    logic [31:0] dout;
    logic        ready;
    logic        mis_err;
    logic        proto_err;
    logic        sticky;
`ifdef BRQ_DMEM_PERF_CNT_EN
    logic [31:0] load_cnt;
    logic [31:0] store_cnt;
`endif

    brq_dmem_responder #(
        .DataWidth  (32),
        .AddrWidth  (c_aw),
        .INIT_CLEAR (1)
    ) dut (
        .brq_clk           (clk),
        .brq_rst           (rst_n),
        .Data_mem_address  (addr),
        .Data_mem_dataIn   (din),
        .Data_mem_read_en  (rd_en),
        .Data_mem_write_en (wr_en),
        .ldst_byte_en      (sz),
        .Data_mem_dataOut  (dout),
        .dmem_ready        (ready),
        .dmem_misalign_err (mis_err),
        .dmem_proto_err    (proto_err),
        .dmem_err_sticky   (sticky)
`ifdef BRQ_DMEM_PERF_CNT_EN
        ,
        .dmem_load_cnt     (load_cnt),
        .dmem_store_cnt    (store_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] dout;
        bit          mis;
        bit          proto;
        bit          sticky;
        logic [31:0] lc;
        logic [31:0] sc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [7:0]  m_mem [64];
    logic [31:0] m_dout;
    bit          m_sticky;
    logic [31:0] m_lc;
    logic [31:0] m_sc;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_mis(input logic [2:0] s, input int a);
        case (s)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return (a % 2) != 0;
            3'd2:       return (a % 4) != 0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] s, input int a);
        logic [7:0]  b;
        logic [15:0] h;
        b = m_mem[a];
        h = {m_mem[(a + 1) % 64], m_mem[a]};
        case (s)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'h0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'h0, h};
            default: return {m_mem[a + 3], m_mem[a + 2], m_mem[a + 1], m_mem[a]};
        endcase
    endfunction

    task automatic model_store(input logic [2:0] s, input int a, input logic [31:0] d);
        case (s)
            3'd0, 3'd4: m_mem[a] = d[7:0];
            3'd1, 3'd5: begin
                m_mem[a]     = d[7:0];
                m_mem[a + 1] = d[15:8];
            end
            default: begin
                for (int i = 0; i < 4; i++) m_mem[a + i] = d[8*i +: 8];
            end
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
        m_dout   = 32'h0;
        m_sticky = 1'b0;
        m_lc     = 32'h0;
        m_sc     = 32'h0;
        q.delete();
    endtask

    // One request cycle: drive inputs just after the edge and predict the response.
    task automatic drive(input bit rd, input bit wr, input logic [2:0] s, input logic [5:0] a,
                         input logic [31:0] d);
        exp_t e;
        bit   mis;
        @(posedge clk);
        #1;
        rd_en = rd;
        wr_en = wr;
        sz    = s;
        addr  = a;
        din   = d;
        mis   = (rd || wr) && model_mis(s, int'(a));
        if (wr && !mis) begin
            model_store(s, int'(a), d);
            m_sc = m_sc + 32'd1;
        end
        if (rd && !wr) begin
            m_dout = mis ? 32'h0 : model_load(s, int'(a));
            if (!mis) m_lc = m_lc + 32'd1;
        end
        e.proto = rd && wr;
        e.mis   = mis;
        if (e.mis || e.proto) m_sticky = 1'b1;
        e.due    = cyc + 1;
        e.dout   = m_dout;
        e.sticky = m_sticky;
        e.lc     = m_lc;
        e.sc     = m_sc;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'd0, 6'd0, 32'h0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    endtask

    // Count cycles of dmem_ready low after reset release; requests must be ignored.
    task automatic init_count(input int exp_cycles, input bit junk);
        int n = 0;
        if (junk) begin
            rd_en = 1'b1;
            wr_en = 1'b1;
            sz    = 3'd3;
            addr  = 6'd1;
            din   = 32'hFFFF_FFFF;
        end
        do begin
            @(posedge clk);
            #1;
            n++;
            chk("init_dout", dout, 32'h0);
            chk("init_mis", mis_err, 0);
            chk("init_proto", proto_err, 0);
        end while (!ready && n < 100);
        chk("init_cycles", n, exp_cycles);
        rd_en = 1'b0;
        wr_en = 1'b0;
        sz    = 3'd0;
        addr  = 6'd0;
        din   = 32'h0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: compare every predicted response in the cycle it is due.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                while (q.size() > 0 && q[0].due < cyc) begin
                    mon_e = q.pop_front();
                    chk("missed_response", cyc, mon_e.due);
                end
                if (q.size() > 0 && q[0].due == cyc) begin
                    mon_e = q.pop_front();
                    chk("dataOut", dout, mon_e.dout);
                    chk("misalign_err", mis_err, mon_e.mis);
                    chk("proto_err", proto_err, mon_e.proto);
                    chk("err_sticky", sticky, mon_e.sticky);
                    chk("ready", ready, 1);
`ifdef BRQ_DMEM_PERF_CNT_EN
                    chk("load_cnt", load_cnt, mon_e.lc);
                    chk("store_cnt", store_cnt, mon_e.sc);
`endif
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          rd;
        bit          wr;
        int          r;
        logic [2:0]  s;
        logic [5:0]  a;
        logic [2:0]  sizes [5];
        logic [2:0]  rsvd [3];
        sizes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        rsvd  = '{3'd3, 3'd6, 3'd7};

        rst_n = 1'b0;
        rd_en = 1'b0;
        wr_en = 1'b0;
        sz    = 3'd0;
        addr  = 6'd0;
        din   = 32'h0;
        model_reset();
        #12;
        chk("rst_dout", dout, 32'h0);
        chk("rst_mis", mis_err, 0);
        chk("rst_proto", proto_err, 0);
        chk("rst_sticky", sticky, 0);
        chk("rst_ready", ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        init_count(16, 1'b1);
        mon_en = 1'b1;

        // Directed scenarios
        drive(1, 0, 3'd2, 6'h3C, 32'h0);
        drive(0, 1, 3'd2, 6'h10, 32'h80FF7F01);
        drive(1, 0, 3'd0, 6'h11, 32'h0);
        drive(1, 0, 3'd0, 6'h13, 32'h0);
        drive(1, 0, 3'd4, 6'h13, 32'h0);
        drive(1, 0, 3'd5, 6'h12, 32'h0);
        drive(0, 1, 3'd2, 6'h14, 32'h11223344);
        drive(0, 1, 3'd0, 6'h16, 32'h000000AB);
        drive(1, 0, 3'd2, 6'h14, 32'h0);
        drive(0, 1, 3'd1, 6'h21, 32'h00005555);
        drive(1, 0, 3'd2, 6'h20, 32'h0);
        drive(1, 0, 3'd2, 6'h22, 32'h0);
        drive(1, 1, 3'd2, 6'h08, 32'hDEADBEEF);
        drive(1, 0, 3'd2, 6'h08, 32'h0);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 9);
            rd = (r < 4) || (r == 8);
            wr = (r >= 4 && r < 8) || (r == 8);
            if ($urandom_range(0, 9) == 0) s = rsvd[$urandom_range(0, 2)];
            else s = sizes[$urandom_range(0, 4)];
            a = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (s == 3'd1 || s == 3'd5) a[0] = 1'b0;
                if (s == 3'd2) a[1:0] = 2'b00;
            end
            drive(rd, wr, s, a, $urandom);
        end
        idle(3);
        wait_drain();

        // Asynchronous reset during operation
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dout", dout, 32'h0);
        chk("async_rst_mis", mis_err, 0);
        chk("async_rst_proto", proto_err, 0);
        chk("async_rst_sticky", sticky, 0);
        chk("async_rst_ready", ready, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midinit_rst_ready", ready, 0);
        chk("midinit_rst_dout", dout, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        init_count(16, 1'b0);

        // Memory cleared again; 3 loads + 2 stores for the counters
        drive(1, 0, 3'd2, 6'h00, 32'h0);
        drive(1, 0, 3'd2, 6'h10, 32'h0);
        drive(1, 0, 3'd2, 6'h08, 32'h0);
        drive(0, 1, 3'd2, 6'h04, 32'hCAFEF00D);
        drive(0, 1, 3'd1, 6'h06, 32'h00001234);
        idle(2);
        wait_drain();
`ifdef BRQ_DMEM_PERF_CNT_EN
        chk("final_load_cnt", load_cnt, 32'd3);
        chk("final_store_cnt", store_cnt, 32'd2);
`endif
        drive(1, 0, 3'd2, 6'h04, 32'h0);
        idle(2);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
